// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two dmem requesters, the arbiter and dmem.
// Ports: m0_*/m1_* requester handshakes, mem_* dmem side; master = requesters+dmem, slave = arbiter.
interface dmem_arbiter_if #(
    parameter int N = 32
);
    logic         m0_req;
    logic         m0_we;
    logic [N-1:0] m0_addr;
    logic [N-1:0] m0_wdata;
    logic         m0_lock;
    logic         m0_gnt;
    logic         m0_rvalid;
    logic [N-1:0] m0_rdata;

    logic         m1_req;
    logic         m1_we;
    logic [N-1:0] m1_addr;
    logic [N-1:0] m1_wdata;
    logic         m1_lock;
    logic         m1_gnt;
    logic         m1_rvalid;
    logic [N-1:0] m1_rdata;

    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: registered grant FSM, optional lock hold, 1-cycle read return.
// Ports: clk, reset (async, active high), bus (slave modport), owner (00 idle, 01 port0, 10 port1).
// Macro ARB_ROUND_ROBIN_EN: ties alternate by last grant; undefined gives port 0 fixed priority.
module dmem_arbiter #(
    parameter int n        = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus,
    output logic [1:0]    owner
);
    localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CW-1:0] CAP = CW'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t        state_q, state_d;
    state_t        arb_s, tie_s;
    logic [CW-1:0] lock_q, lock_d;
    logic          last_q, last_d;
    logic          rvalid0_q, rvalid1_q;
    logic [n-1:0]  rdata0_q, rdata1_q;
    logic          gnt0, gnt1;
    logic          hold0, hold1;

    assign gnt0  = (state_q == GNT0) && bus.m0_req;
    assign gnt1  = (state_q == GNT1) && bus.m1_req;
    assign hold0 = bus.m0_lock && bus.m0_req;
    assign hold1 = bus.m1_lock && bus.m1_req;

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_s = last_q ? GNT0 : GNT1;
`else
    logic last_unused;
    assign last_unused = last_q;
    assign tie_s = GNT0;
`endif

    always_comb begin
        arb_s = IDLE;
        if (bus.m0_req && bus.m1_req) begin
            arb_s = tie_s;
        end else if (bus.m0_req) begin
            arb_s = GNT0;
        end else if (bus.m1_req) begin
            arb_s = GNT1;
        end
    end

    // A locked owner stays until the cap; at the cap a waiting peer takes over.
    always_comb begin
        state_d = arb_s;
        unique case (state_q)
            GNT0: begin
                if (hold0 && lock_q < CAP) begin
                    state_d = GNT0;
                end else if (hold0 && bus.m1_req) begin
                    state_d = GNT1;
                end
            end
            GNT1: begin
                if (hold1 && lock_q < CAP) begin
                    state_d = GNT1;
                end else if (hold1 && bus.m0_req) begin
                    state_d = GNT0;
                end
            end
            default: state_d = arb_s;
        endcase

        lock_d = '0;
        if (state_q != IDLE && state_d == state_q) begin
            lock_d = (lock_q == CAP) ? CAP : lock_q + 1'b1;
        end

        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lock_q    <= '0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            last_q    <= last_d;
            rvalid0_q <= gnt0 && !bus.m0_we;
            rvalid1_q <= gnt1 && !bus.m1_we;
            if (gnt0 && !bus.m0_we) begin
                rdata0_q <= bus.mem_rdata;
            end
            if (gnt1 && !bus.m1_we) begin
                rdata1_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m1_rvalid = rvalid1_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;

    assign bus.mem_we    = (gnt0 && bus.m0_we) || (gnt1 && bus.m1_we);
    assign bus.mem_addr  = gnt0 ? bus.m0_addr  : (gnt1 ? bus.m1_addr  : '0);
    assign bus.mem_wdata = gnt0 ? bus.m0_wdata : (gnt1 ? bus.m1_wdata : '0);

    assign owner = state_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a rule-level model.
// Ports: none; drives the bus interface, models dmem, checks every cycle.
module tb_dmem_arbiter;
    localparam int N  = 32;
    localparam int ML = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] owner;

    dmem_arbiter_if #(.N(N)) bus ();

    dmem_arbiter #(.n(N), .MAX_LOCK(ML)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .owner (owner)
    );

    always #5 clk = ~clk;

    logic [31:0] dmem [16];
    logic [31:0] gmem [16];
    assign bus.mem_rdata = dmem[bus.mem_addr[5:2]];

    int checks = 0;
    int errors = 0;

    int          m_own;
    int          m_run;
`ifdef ARB_ROUND_ROBIN_EN
    int          m_last;
`endif
    logic        e_rv0, e_rv1;
    logic [31:0] e_rd0, e_rd1;
    logic        eg0, eg1;
    int          c0, c1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0;
        m_run = 0;
`ifdef ARB_ROUND_ROBIN_EN
        m_last = 1;
`endif
        e_rv0 = 1'b0;
        e_rv1 = 1'b0;
        e_rd0 = '0;
        e_rd1 = '0;
    endtask

    task automatic clear_inputs();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0;
        bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0;
        bus.m1_addr = '0; bus.m1_wdata = '0;
    endtask

    // Owner codes: 0 none, 1 port 0, 2 port 1.
    function automatic int pick(input logic r0, input logic r1);
        if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (m_last == 1) ? 1 : 2;
`else
            return 1;
`endif
        end
        if (r0) return 1;
        if (r1) return 2;
        return 0;
    endfunction

    task automatic settle();
        logic        ew;
        logic [31:0] ea, ed;
        #1;
        eg0 = (m_own == 1) && bus.m0_req;
        eg1 = (m_own == 2) && bus.m1_req;
        ew  = (eg0 && bus.m0_we) || (eg1 && bus.m1_we);
        ea  = eg0 ? bus.m0_addr  : (eg1 ? bus.m1_addr  : 32'h0);
        ed  = eg0 ? bus.m0_wdata : (eg1 ? bus.m1_wdata : 32'h0);
        chk("m0_gnt", 32'(bus.m0_gnt), 32'(eg0));
        chk("m1_gnt", 32'(bus.m1_gnt), 32'(eg1));
        chk("mem_we", 32'(bus.mem_we), 32'(ew));
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_wdata", bus.mem_wdata, ed);
        chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(e_rv0));
        chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(e_rv1));
        chk("m0_rdata", bus.m0_rdata, e_rd0);
        chk("m1_rdata", bus.m1_rdata, e_rd1);
        chk("owner", 32'(owner), 32'(m_own));
    endtask

    task automatic advance();
        int   nxt, x;
        logic xr, xl, orq;
        if (reset) begin
            model_reset();
        end else begin
            if (m_own == 0) begin
                nxt = pick(bus.m0_req, bus.m1_req);
            end else begin
                x   = m_own;
                xr  = (x == 1) ? bus.m0_req  : bus.m1_req;
                xl  = (x == 1) ? bus.m0_lock : bus.m1_lock;
                orq = (x == 1) ? bus.m1_req  : bus.m0_req;
                if (xl && xr && m_run < ML - 1) nxt = x;
                else if (xl && xr && orq) nxt = 3 - x;
                else nxt = pick(bus.m0_req, bus.m1_req);
            end
            if (m_own != 0 && nxt == m_own)
                m_run = (m_run < ML - 1) ? m_run + 1 : m_run;
            else
                m_run = 0;
            e_rv0 = eg0 && !bus.m0_we;
            e_rv1 = eg1 && !bus.m1_we;
            if (e_rv0) e_rd0 = gmem[bus.m0_addr[5:2]];
            if (e_rv1) e_rd1 = gmem[bus.m1_addr[5:2]];
            if (eg0 && bus.m0_we) gmem[bus.m0_addr[5:2]] = bus.m0_wdata;
            if (eg1 && bus.m1_we) gmem[bus.m1_addr[5:2]] = bus.m1_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            if (eg0) m_last = 0;
            if (eg1) m_last = 1;
`endif
            m_own = nxt;
        end
        if (bus.mem_we) dmem[bus.mem_addr[5:2]] = bus.mem_wdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        clear_inputs();
        for (int i = 0; i < k; i++) begin
            settle();
            advance();
        end
    endtask

    task automatic rnd(input logic gr, input logic req_i, input logic we_i,
                       input logic [31:0] addr_i, input logic [31:0] wdata_i,
                       output logic req, output logic we, output logic lock,
                       output logic [31:0] addr, output logic [31:0] wdata);
        req   = req_i;
        we    = we_i;
        addr  = addr_i;
        wdata = wdata_i;
        if (!req_i || gr) begin
            req = ($urandom_range(0, 1) == 1);
            if (req) begin
                we    = ($urandom_range(0, 1) == 1);
                addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                wdata = $urandom();
            end
        end else if ($urandom_range(0, 7) == 0) begin
            req = 1'b0;
        end
        lock = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        for (int i = 0; i < 16; i++) begin
            dmem[i] = $urandom();
            gmem[i] = dmem[i];
        end
        model_reset();
        @(negedge clk);
        settle();
        chk("rst_owner", 32'(owner), 32'h0);
        advance();
        reset = 1'b0;

        // Reset in the middle of a port 1 write grant
        bus.m1_req = 1; bus.m1_we = 1;
        bus.m1_addr = 32'h30; bus.m1_wdata = 32'hCAFEF00D;
        settle();
        advance();
        chk("t1_pre_gnt", 32'(bus.m1_gnt), 32'h1);
        reset = 1'b1;
        model_reset();
        settle();
        chk("t1_mem_we", 32'(bus.mem_we), 32'h0);
        chk("t1_owner", 32'(owner), 32'h0);
        chk("t1_rvalid", 32'(bus.m1_rvalid), 32'h0);
        advance();
        reset = 1'b0;
        idle(1);
        chk("t1_nowrite", dmem[12], gmem[12]);

        // Single read, latency t+1 grant, t+2 data
        dmem[4] = 32'hDEADBEEF;
        gmem[4] = 32'hDEADBEEF;
        bus.m0_req = 1; bus.m0_addr = 32'h10;
        settle();
        chk("t2_gnt_t", 32'(bus.m0_gnt), 32'h0);
        advance();
        settle();
        chk("t2_gnt_t1", 32'(bus.m0_gnt), 32'h1);
        advance();
        bus.m0_req = 0;
        settle();
        chk("t2_rvalid", 32'(bus.m0_rvalid), 32'h1);
        chk("t2_rdata", bus.m0_rdata, 32'hDEADBEEF);
        advance();
        settle();
        chk("t2_pulse", 32'(bus.m0_rvalid), 32'h0);
        advance();

        // Port 1 write then port 0 read-back
        clear_inputs();
        bus.m1_req = 1; bus.m1_we = 1;
        bus.m1_addr = 32'h20; bus.m1_wdata = 32'h12345678;
        settle();
        advance();
        settle();
        chk("t3_m1_gnt", 32'(bus.m1_gnt), 32'h1);
        chk("t3_mem_we", 32'(bus.mem_we), 32'h1);
        advance();
        clear_inputs();
        bus.m0_req = 1; bus.m0_addr = 32'h20;
        settle();
        chk("t3_m1_once", 32'(bus.m1_gnt), 32'h0);
        advance();
        settle();
        chk("t3_m0_gnt", 32'(bus.m0_gnt), 32'h1);
        advance();
        bus.m0_req = 0;
        settle();
        chk("t3_rdata", bus.m0_rdata, 32'h12345678);
        advance();
        idle(2);

        // Both ports requesting continuously
        bus.m0_req = 1; bus.m0_addr = 32'h0;
        bus.m1_req = 1; bus.m1_addr = 32'h4;
        settle();
        advance();
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 8; i++) begin
            settle();
            c0 += int'(bus.m0_gnt);
            c1 += int'(bus.m1_gnt);
            advance();
        end
`ifdef ARB_ROUND_ROBIN_EN
        chk("t4_c0", 32'(c0), 32'd4);
        chk("t4_c1", 32'(c1), 32'd4);
`else
        chk("t4_c0", 32'(c0), 32'd8);
        chk("t4_c1", 32'(c1), 32'd0);
`endif
        idle(2);

        // Locked port 1 holds for MAX_LOCK grants
        bus.m1_req = 1; bus.m1_lock = 1; bus.m1_addr = 32'h8;
        settle();
        advance();
        bus.m0_req = 1; bus.m0_addr = 32'hC;
        for (int i = 0; i < ML; i++) begin
            settle();
            chk("t5_m1_held", 32'(bus.m1_gnt), 32'h1);
            advance();
        end
        settle();
        chk("t5_m0_gnt", 32'(bus.m0_gnt), 32'h1);
        chk("t5_m1_off", 32'(bus.m1_gnt), 32'h0);
        advance();
        idle(3);

        // Owner drops request while granted
        bus.m0_req = 1; bus.m0_addr = 32'h14;
        settle();
        advance();
        settle();
        advance();
        bus.m0_req = 0;
        bus.m1_req = 1; bus.m1_addr = 32'h18;
        settle();
        chk("t6_no_gnt", 32'(bus.m0_gnt), 32'h0);
        chk("t6_no_addr", bus.mem_addr, 32'h0);
        advance();
        settle();
        chk("t6_m1_gnt", 32'(bus.m1_gnt), 32'h1);
        chk("t6_rv_off", 32'(bus.m0_rvalid), 32'h0);
        advance();
        idle(2);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) begin
                reset = 1'b1;
                model_reset();
            end
            rnd(eg0, bus.m0_req, bus.m0_we, bus.m0_addr, bus.m0_wdata,
                bus.m0_req, bus.m0_we, bus.m0_lock, bus.m0_addr, bus.m0_wdata);
            rnd(eg1, bus.m1_req, bus.m1_we, bus.m1_addr, bus.m1_wdata,
                bus.m1_req, bus.m1_we, bus.m1_lock, bus.m1_addr, bus.m1_wdata);
            settle();
            advance();
            if (k == 1500) reset = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
